// File: rtl/serial_adder_if.sv
// serial_adder_if: start/operand request and busy/done/result bundle for the bit-serial adder
interface serial_adder_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  modport master (output start, a, b, cin, input busy, done, sum, cout, overflow);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout, overflow);
endinterface

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: WIDTH-bit adder computed one bit per clock through a single full adder cell
module full_adder_decoder_gate (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic [7:0] m;
  assign m[0] = ~a & ~b & ~ci;
  assign m[1] = ~a & ~b &  ci;
  assign m[2] = ~a &  b & ~ci;
  assign m[3] = ~a &  b &  ci;
  assign m[4] =  a & ~b & ~ci;
  assign m[5] =  a & ~b &  ci;
  assign m[6] =  a &  b & ~ci;
  assign m[7] =  a &  b &  ci;
  assign s  = m[1] | m[2] | m[4] | m[7];
  assign co = m[3] | m[5] | m[6] | m[7];
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  serial_adder_if.slave bus
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d, b_sr_q, b_sr_d, sum_sr_q, sum_sr_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic             fa_s, fa_c;
  full_adder_decoder_gate u_fa (
    .a (a_sr_q[0]),
    .b (b_sr_q[0]),
    .ci(carry_q),
    .s (fa_s),
    .co(fa_c)
  );
  // capture on start, shift one bit per RUN cycle, publish result on the last bit
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: if (bus.start) begin
        a_sr_d  = bus.a;
        b_sr_d  = bus.b;
        carry_d = bus.cin;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        sum_sr_d = (sum_sr_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        carry_d  = fa_c;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = sum_sr_d;
          cout_d  = fa_c;
          ovf_d   = carry_q ^ fa_c;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers, all cleared by reset including the held result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end
  assign bus.busy     = state_q == RUN;
  assign bus.done     = state_q == DONE;
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: WIDTH 8/4/1 adders against a timestamp/arithmetic model plus literal checks
module tb_serial_adder_ctrl;
  localparam int WL[3] = '{8, 4, 1};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic        st[3];
  logic [31:0] av[3], bv[3];
  logic        cv[3];
  serial_adder_if #(.WIDTH(8)) i8 ();
  serial_adder_if #(.WIDTH(4)) i4 ();
  serial_adder_if #(.WIDTH(1)) i1 ();
  assign i8.start = st[0];
  assign i8.a = av[0][7:0];
  assign i8.b = bv[0][7:0];
  assign i8.cin = cv[0];
  assign i4.start = st[1];
  assign i4.a = av[1][3:0];
  assign i4.b = bv[1][3:0];
  assign i4.cin = cv[1];
  assign i1.start = st[2];
  assign i1.a = av[2][0:0];
  assign i1.b = bv[2][0:0];
  assign i1.cin = cv[2];
  serial_adder_ctrl #(.WIDTH(8)) d8 (.clk(clk), .rst_n(rst_n), .bus(i8));
  serial_adder_ctrl #(.WIDTH(4)) d4 (.clk(clk), .rst_n(rst_n), .bus(i4));
  serial_adder_ctrl #(.WIDTH(1)) d1 (.clk(clk), .rst_n(rst_n), .bus(i1));

  // model: an accepted start at edge t0 gives busy after edges t0..t0+W-1, done and the new result after t0+W
  int          cyc = 0;
  int          t0[3], free_at[3];
  logic [31:0] res_sum[3], e_sum[3];
  logic        res_c[3], res_v[3], e_busy[3], e_done[3], e_c[3], e_v[3];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < 3; l++) begin
        t0[l] <= -1000;
        free_at[l] <= 0;
        e_busy[l] <= 1'b0;
        e_done[l] <= 1'b0;
        e_c[l] <= 1'b0;
        e_v[l] <= 1'b0;
        e_sum[l] <= '0;
      end
    end else begin
      cyc <= cyc + 1;
      for (int l = 0; l < 3; l++) begin
        automatic int w = WL[l];
        automatic longint mask = (64'd1 << w) - 1;
        automatic longint lmask = (64'd1 << (w - 1)) - 1;
        automatic longint tot = (longint'(av[l]) & mask) + (longint'(bv[l]) & mask) + longint'(cv[l]);
        automatic longint cmsb = ((longint'(av[l]) & lmask) + (longint'(bv[l]) & lmask) + longint'(cv[l])) >> (w - 1);
        automatic logic acc = st[l] && cyc >= free_at[l];
        if (acc) begin
          t0[l] <= cyc;
          free_at[l] <= cyc + w + 2;
          res_sum[l] <= 32'(tot & mask);
          res_c[l] <= tot[w];
          res_v[l] <= cmsb[0] ^ tot[w];
        end
        e_busy[l] <= acc || (cyc > t0[l] && cyc < t0[l] + w);
        e_done[l] <= cyc == t0[l] + w;
        if (cyc == t0[l] + w) begin
          e_sum[l] <= res_sum[l];
          e_c[l] <= res_c[l];
          e_v[l] <= res_v[l];
        end
      end
    end
  end

  function automatic logic [35:0] act_of(int l);
    case (l)
      0: return {i8.busy, i8.done, i8.cout, i8.overflow, 32'(i8.sum)};
      1: return {i4.busy, i4.done, i4.cout, i4.overflow, 32'(i4.sum)};
      default: return {i1.busy, i1.done, i1.cout, i1.overflow, 32'(i1.sum)};
    endcase
  endfunction

  function automatic longint res(logic c, logic v, logic [31:0] s);
    return (longint'(c) << 33) | (longint'(v) << 32) | longint'(s);
  endfunction

  // literal checks are posted by the stimulus and judged here alongside the model
  int     n_run = 0, n_fail = 0;
  int     lit_seq = 0, lit_seen = 0;
  string  lit_name;
  longint lit_act, lit_exp;
  always @(negedge clk) begin
    for (int l = 0; l < 3; l++) begin
      automatic logic [35:0] act = act_of(l);
      automatic logic [35:0] exp = {e_busy[l], e_done[l], e_c[l], e_v[l], e_sum[l]};
      n_run++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL model W=%0d cyc=%0d: got busy=%b done=%b cout=%b ovf=%b sum=%h, need busy=%b done=%b cout=%b ovf=%b sum=%h",
                 WL[l], cyc, act[35], act[34], act[33], act[32], act[31:0],
                 exp[35], exp[34], exp[33], exp[32], exp[31:0]);
      end
    end
    if (lit_seq != lit_seen) begin
      lit_seen = lit_seq;
      n_run++;
      if (lit_act !== lit_exp) begin
        n_fail++;
        $display("FAIL %s: got %h, need %h", lit_name, lit_act, lit_exp);
      end
    end
  end

  task automatic post(string nm, longint act, longint exp);
    lit_name = nm;
    lit_act = act;
    lit_exp = exp;
    lit_seq++;
    @(negedge clk);
    #1;
  endtask

  task automatic go(int l, logic [31:0] a, logic [31:0] b, logic c);
    av[l] = a;
    bv[l] = b;
    cv[l] = c;
    st[l] = 1'b1;
    @(negedge clk);
    #1;
    st[l] = 1'b0;
    av[l] = ~a;
    bv[l] = ~b;
    cv[l] = ~c;
  endtask

  task automatic op8(string nm, logic [7:0] a, logic [7:0] b, logic c, logic [7:0] s, logic co, logic v);
    int k, nb;
    go(0, 32'(a), 32'(b), c);
    k = 0;
    nb = int'(i8.busy);
    while (!i8.done && k < 20) begin
      @(negedge clk);
      #1;
      k++;
      nb += int'(i8.busy);
    end
    post({nm, " latency"}, k, 8);
    post({nm, " busy cycles"}, nb, 8);
    post({nm, " result"}, res(i8.cout, i8.overflow, 32'(i8.sum)), res(co, v, 32'(s)));
  endtask

  initial begin
    int nd;
    for (int l = 0; l < 3; l++) begin
      st[l] = 1'b0;
      av[l] = '0;
      bv[l] = '0;
      cv[l] = 1'b0;
    end
    @(negedge clk);
    #1;
    post("reset outputs", longint'(act_of(0)), 0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    op8("0F+01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    op8("FF+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    op8("FF+FF+1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    op8("7F+01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    op8("80+80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    go(0, 32'h10, 32'h20, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    go(0, 32'h01, 32'h01, 1'b0);
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      #1;
      nd += int'(i8.done);
    end
    post("start in RUN ignored: done count", nd, 1);
    post("start in RUN ignored: result", res(i8.cout, i8.overflow, 32'(i8.sum)), res(1'b0, 1'b0, 32'h30));
    av[0] = 32'h03;
    bv[0] = 32'h04;
    cv[0] = 1'b0;
    st[0] = 1'b1;
    nd = 0;
    repeat (30) begin
      @(negedge clk);
      #1;
      nd += int'(i8.done);
    end
    st[0] = 1'b0;
    post("held start: done count in 30 cycles", nd, 3);
    repeat (12) @(negedge clk);
    #1;
    go(0, 32'h55, 32'h22, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    post("reset mid-run clears outputs", longint'(act_of(0)), 0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    op8("05+03 after reset", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0);
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++) begin
          go(1, 32'(a), 32'(b), c[0]);
          repeat (5) @(negedge clk);
          #1;
        end
    go(1, 32'h7, 32'h1, 1'b0);
    repeat (5) @(negedge clk);
    #1;
    post("W4 7+1", res(i4.cout, i4.overflow, 32'(i4.sum)), res(1'b0, 1'b1, 32'h8));
    for (int k = 0; k < 8; k++) begin
      go(2, 32'(k[2]), 32'(k[1]), k[0]);
      repeat (2) @(negedge clk);
      #1;
    end
    post("W1 1+1+1", res(i1.cout, i1.overflow, 32'(i1.sum)), res(1'b1, 1'b0, 32'h1));
    go(2, 32'h0, 32'h0, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    post("W1 0+0+1", res(i1.cout, i1.overflow, 32'(i1.sum)), res(1'b0, 1'b1, 32'h1));
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
